// File: rtl/top.sv
// Parity-checked show-ahead FIFO: top_fifo stores words verbatim and
// top filters the head word through a combinational parity checker.

module top_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH:0]   push_data_i,
    input  logic                  push_valid_i,
    output logic                  push_grant_o,
    input  logic                  pop_grant_i,
    output logic [DATA_WIDTH:0]   pop_data_o,
    output logic                  pop_valid_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    count_write;
    logic [PTR_W-1:0]    count_read;
    logic [CNT_W-1:0]    count_fifo;
    logic                do_write;
    logic                do_read;

    // No bypass: a full FIFO refuses a push even when a pop frees a slot.
    assign push_grant_o = (count_fifo < CNT_W'(FIFO_DEPTH));
    assign pop_valid_o  = (count_fifo != '0);
    assign do_write     = push_valid_i && push_grant_o;
    assign do_read      = pop_grant_i && pop_valid_o;
    assign pop_data_o   = mem[count_read];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            count_write <= '0;
            count_read  <= '0;
            count_fifo  <= '0;
        end else begin
            if (do_write) count_write <= next_ptr(count_write);
            if (do_read)  count_read  <= next_ptr(count_read);
            case ({do_write, do_read})
                2'b10:   count_fifo <= count_fifo + CNT_W'(1);
                2'b01:   count_fifo <= count_fifo - CNT_W'(1);
                default: count_fifo <= count_fifo;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && do_write) mem[count_write] <= push_data_i;
    end

endmodule

module top #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned EVEN_ODD   = 0,
    parameter int unsigned PARITY_BIT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH:0]   push_data_i,
    input  logic                  push_valid_i,
    output logic                  push_grant_o,
    input  logic                  pop_grant_i,
    output logic [DATA_WIDTH:0]   pop_data_o,
    output logic                  pop_valid_o
);

    localparam logic [DATA_WIDTH:0] PAR_MASK = {{DATA_WIDTH{1'b0}}, 1'b1} << PARITY_BIT;

    logic [DATA_WIDTH:0] fifo_data;
    logic                fifo_valid;
    logic                data_xor;
    logic                word_good;

    top_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) fifo_i (
        .clk          (clk),
        .rst          (rst),
        .push_data_i  (push_data_i),
        .push_valid_i (push_valid_i),
        .push_grant_o (push_grant_o),
        .pop_grant_i  (pop_grant_i),
        .pop_data_o   (fifo_data),
        .pop_valid_o  (fifo_valid)
    );

    // Payload XOR with the parity bit folded back in covers the whole word.
    always_comb begin
        data_xor  = ^(fifo_data & ~PAR_MASK);
        word_good = ((data_xor ^ fifo_data[PARITY_BIT]) == 1'(EVEN_ODD));
    end

    assign pop_data_o  = fifo_data;
    assign pop_valid_o = fifo_valid && word_good;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: constant vector table plus a queue
// scoreboard for concurrent, reset and random traffic.

module tb_top;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW:0]   push_data_i;
    logic          push_valid_i;
    logic          push_grant_o;
    logic          pop_grant_i;
    logic [DW:0]   pop_data_o;
    logic          pop_valid_o;

    int vectors = 0;
    int miscompares = 0;
    logic [DW:0] model_q[$];

    top #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .EVEN_ODD(0), .PARITY_BIT(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .push_data_i  (push_data_i),
        .push_valid_i (push_valid_i),
        .push_grant_o (push_grant_o),
        .pop_grant_i  (pop_grant_i),
        .pop_data_o   (pop_data_o),
        .pop_valid_o  (pop_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [DW:0] pd;
        logic        pg;
        logic        exp_grant;
        logic        exp_valid;
        logic        chk_data;
        logic [DW:0] exp_data;
        int          exp_count;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic good_par(input logic [DW:0] w);
        return ($countones(w) % 2) == 0;
    endfunction

    // One scoreboard cycle: drive, check head/grant before the edge, update model, check count after.
    task automatic sb_step(input logic pv, input logic [DW:0] pd, input logic pg, input bit check_le1);
        int sz;
        @(negedge clk);
        push_valid_i = pv;
        push_data_i  = pd;
        pop_grant_i  = pg;
        #1;
        sz = model_q.size();
        check("sb_push_grant", 64'(push_grant_o), 64'(sz < DEPTH));
        if (sz == 0) begin
            check("sb_valid_empty", 64'(pop_valid_o), 64'd0);
        end else begin
            check("sb_valid", 64'(pop_valid_o), 64'(good_par(model_q[0])));
            if (good_par(model_q[0])) check("sb_data", 64'(pop_data_o), 64'(model_q[0]));
        end
        @(posedge clk);
        if (pg && sz > 0) void'(model_q.pop_front());
        if (pv && sz < DEPTH) model_q.push_back(pd);
        #1;
        check("sb_count", 64'(dut.fifo_i.count_fifo), 64'(model_q.size()));
        if (check_le1) check("sb_count_le1", 64'(dut.fifo_i.count_fifo <= 1), 64'd1);
    endtask

    task automatic do_reset(input logic pv, input logic pg);
        @(negedge clk);
        rst = 1'b1;
        push_valid_i = pv;
        push_data_i  = 33'h3;
        pop_grant_i  = pg;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        check("rst_count_read",  64'(dut.fifo_i.count_read),  64'd0);
        check("rst_count_write", 64'(dut.fifo_i.count_write), 64'd0);
        check("rst_count_fifo",  64'(dut.fifo_i.count_fifo),  64'd0);
        check("rst_pop_valid",   64'(pop_valid_o),  64'd0);
        check("rst_push_grant",  64'(push_grant_o), 64'd1);
    endtask

    vec_t vt[$];

    function automatic vec_t mk(input logic pv, input logic [DW:0] pd, input logic pg,
                                input logic eg, input logic ev, input logic cd,
                                input logic [DW:0] ed, input int ec);
        vec_t v;
        v.pv = pv; v.pd = pd; v.pg = pg; v.exp_grant = eg; v.exp_valid = ev;
        v.chk_data = cd; v.exp_data = ed; v.exp_count = ec;
        return v;
    endfunction

    initial begin
        rst = 1'b0;
        push_valid_i = 1'b0;
        push_data_i  = '0;
        pop_grant_i  = 1'b0;

        // Overflow: six pushes into a depth-4 FIFO.
        vt.push_back(mk(1, 33'h3,  0, 1, 0, 0, 33'h0, 1));
        vt.push_back(mk(1, 33'h5,  0, 1, 1, 1, 33'h3, 2));
        vt.push_back(mk(1, 33'h6,  0, 1, 1, 1, 33'h3, 3));
        vt.push_back(mk(1, 33'h9,  0, 1, 1, 1, 33'h3, 4));
        vt.push_back(mk(1, 33'ha,  0, 0, 1, 1, 33'h3, 4));
        vt.push_back(mk(1, 33'hc,  0, 0, 1, 1, 33'h3, 4));
        // Underflow: six pops, last two ignored.
        vt.push_back(mk(0, 33'h0,  1, 0, 1, 1, 33'h3, 3));
        vt.push_back(mk(0, 33'h0,  1, 1, 1, 1, 33'h5, 2));
        vt.push_back(mk(0, 33'h0,  1, 1, 1, 1, 33'h6, 1));
        vt.push_back(mk(0, 33'h0,  1, 1, 1, 1, 33'h9, 0));
        vt.push_back(mk(0, 33'h0,  1, 1, 0, 0, 33'h0, 0));
        vt.push_back(mk(0, 33'h0,  1, 1, 0, 0, 33'h0, 0));
        // Parity: good word 3 then corrupt word 1, which is discarded.
        vt.push_back(mk(1, 33'h3,  0, 1, 0, 0, 33'h0, 1));
        vt.push_back(mk(1, 33'h1,  0, 1, 1, 1, 33'h3, 2));
        vt.push_back(mk(0, 33'h0,  1, 1, 1, 1, 33'h3, 1));
        vt.push_back(mk(0, 33'h0,  1, 1, 0, 1, 33'h1, 0));
        // Full with simultaneous pop: no bypass, the push of 'a' is lost.
        vt.push_back(mk(1, 33'h3,  0, 1, 0, 0, 33'h0, 1));
        vt.push_back(mk(1, 33'h5,  0, 1, 1, 1, 33'h3, 2));
        vt.push_back(mk(1, 33'h6,  0, 1, 1, 1, 33'h3, 3));
        vt.push_back(mk(1, 33'h9,  0, 1, 1, 1, 33'h3, 4));
        vt.push_back(mk(1, 33'ha,  1, 0, 1, 1, 33'h3, 3));
        vt.push_back(mk(0, 33'h0,  1, 1, 1, 1, 33'h5, 2));
        vt.push_back(mk(0, 33'h0,  1, 1, 1, 1, 33'h6, 1));
        vt.push_back(mk(0, 33'h0,  1, 1, 1, 1, 33'h9, 0));
        // Push and pop while empty: only the write happens.
        vt.push_back(mk(1, 33'h11, 1, 1, 0, 0, 33'h0, 1));
        vt.push_back(mk(0, 33'h0,  1, 1, 1, 1, 33'h11, 0));

        do_reset(1'b0, 1'b0);
        do_reset(1'b1, 1'b1);

        foreach (vt[i]) begin
            @(negedge clk);
            push_valid_i = vt[i].pv;
            push_data_i  = vt[i].pd;
            pop_grant_i  = vt[i].pg;
            #1;
            check($sformatf("v%0d_push_grant", i), 64'(push_grant_o), 64'(vt[i].exp_grant));
            check($sformatf("v%0d_pop_valid", i),  64'(pop_valid_o),  64'(vt[i].exp_valid));
            if (vt[i].chk_data)
                check($sformatf("v%0d_pop_data", i), 64'(pop_data_o), 64'(vt[i].exp_data));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), 64'(dut.fifo_i.count_fifo), 64'(vt[i].exp_count));
        end

        // Mid-operation reset discards stored words, even with push/pop asserted.
        sb_step(1, 33'h3, 0, 0);
        sb_step(1, 33'h5, 0, 0);
        sb_step(1, 33'h6, 0, 0);
        do_reset(1'b1, 1'b1);
        sb_step(0, 33'h0, 1, 0);

        // Concurrent push/pop of 3, 6, 9, ... for 30 cycles.
        for (int k = 1; k <= 30; k++) sb_step(1, 33'(3 * k), 1, 1);
        for (int k = 0; k < 3; k++) sb_step(0, 33'h0, 1, 1);

        // Random traffic: push every cycle, pop grant at 50 %.
        for (int k = 0; k < 300; k++)
            sb_step(1, {1'($urandom_range(0, 1)), 32'($urandom)}, 1'($urandom_range(0, 1)), 0);
        for (int k = 0; k < 6; k++) sb_step(0, 33'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
